// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell, LSB first, registered carry, start/busy/done handshake.
// Latency: start accepted at edge k, done pulses in the cycle after edge k+WIDTH.
// Backpressure: start is ignored while busy. The next start can be accepted in the done cycle.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] sum_next;

    full_adder u_fa (
        .A   (a_sh[0]),
        .B   (b_sh[0]),
        .Cin (carry),
        .S   (fa_s),
        .Cout(fa_cout)
    );

    // The current S enters at the MSB, so after WIDTH shifts bit 0 is back at the LSB.
    assign sum_next = {fa_s, sum_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_next;
                    carry  <= fa_cout;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum   <= sum_next;
                        cout  <= fa_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// One-bit full adder cell driven by the serial sequencer above.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder (WIDTH=8) with handshake and reset corner sequences.
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int n_cmp = 0;
    int n_bad = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse start for one cycle, then watch busy/done for at most 20 cycles.
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                          output logic [7:0] rs, output logic rc,
                          output int busy_cyc, output int done_cyc, output logic done_after);
        busy_cyc = 0;
        done_cyc = 0;
        rs = 'x;
        rc = 1'bx;
        done_after = 1'bx;
        @(negedge clk);
        a = va; b = vb; cin = vc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~va; b = ~vb; cin = ~vc;
        for (int n = 1; n <= 20; n++) begin
            if (busy) busy_cyc++;
            if (done) begin
                done_cyc = n;
                rs = sum;
                rc = cout;
                break;
            end
            @(negedge clk);
        end
        if (done_cyc == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: done not seen within 20 cycles");
        end else begin
            @(negedge clk);
            done_after = done;
        end
    endtask

    vec_t       vecs[8];
    logic [7:0] rs;
    logic       rc;
    logic       da;
    int         bc, dc, pulses;

    initial begin
        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

        // Reset and idle behaviour
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", 32'(sum), 32'h00);
        check("reset_cout", 32'(cout), 32'd0);
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("idle_no_done", 32'(pulses), 32'd0);

        // Directed vectors with latency checks
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, bc, dc, da);
            check($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i), 32'(rc), 32'(vecs[i].cout));
            check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'd8);
            check($sformatf("vec%0d_done_cycle", i), 32'(dc), 32'd9);
            check($sformatf("vec%0d_done_width", i), 32'(da), 32'd0);
        end

        // Start while busy is ignored
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hAA; b = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        dc = 0;
        for (int n = 4; n <= 25; n++) begin
            if (busy && done) check("busy_done_overlap", 32'd1, 32'd0);
            if (done) begin
                pulses++;
                if (dc == 0) begin
                    dc = n;
                    rs = sum;
                    rc = cout;
                end
            end
            @(negedge clk);
        end
        check("ignore_sum", 32'(rs), 32'h46);
        check("ignore_cout", 32'(rc), 32'd0);
        check("ignore_done_cycle", 32'(dc), 32'd9);
        check("ignore_done_count", 32'(pulses), 32'd1);

        // Reset in the middle of an operation
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midop_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midop_busy", 32'(busy), 32'd0);
        check("midop_done", 32'(done), 32'd0);
        check("midop_sum", 32'(sum), 32'h00);
        check("midop_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("midop_no_activity", 32'(pulses), 32'd0);
        run_op(8'h80, 8'h80, 1'b0, rs, rc, bc, dc, da);
        check("after_reset_sum", 32'(rs), 32'h00);
        check("after_reset_cout", 32'(rc), 32'd1);

        // Back-to-back: start held high across DONE
        @(negedge clk);
        a = 8'h33; b = 8'h44; cin = 1'b1; start = 1'b1;
        dc = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done) begin
                dc = 1;
                break;
            end
        end
        check("b2b_first_done", 32'(dc), 32'd1);
        check("b2b_first_sum", 32'({cout, sum}), 32'h078);
        a = 8'hC8; b = 8'h64; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("b2b_no_idle", 32'(busy), 32'd1);
        dc = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done) begin
                dc = n + 2;
                break;
            end
        end
        check("b2b_second_done_cycle", 32'(dc), 32'd9);
        check("b2b_second_sum", 32'({cout, sum}), 32'h12C);

        // Random operands against plain integer addition
        pulses = 0;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] ra, rb;
            logic       rcin;
            logic [8:0] exp;
            ra = 8'($urandom_range(255));
            rb = 8'($urandom_range(255));
            rcin = 1'($urandom_range(1));
            exp = 9'(ra) + 9'(rb) + 9'(rcin);
            run_op(ra, rb, rcin, rs, rc, bc, dc, da);
            n_cmp++;
            if ({rc, rs} !== exp) begin
                n_bad++;
                $display("FAIL rand%0d: %0h+%0h+%0h got %0h expected %0h", i, ra, rb, rcin, {rc, rs}, exp);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
